bcd_countdown_timer: RTL

Parametrised multi-digit BCD countdown timer with a loadable preset, start/pause control, a multiplexed 7-segment display driver and an end-of-count alarm tone. It is the general successor to the fixed two-digit 99-to-0 counter/display/buzzer chain. It runs from a single board clock and derives its count tick, display scan and tone internally from clock enables.

---
 rtl/timer_pkg.sv | 35 +++
 rtl/bcd_scan_mux.sv | 69 ++++++
 rtl/bcd_countdown_timer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for bcd_countdown_timer and its display sub-module:
//     - timer_state_t : controller states (IDLE, RUN, PAUSE, ALARM)
//     - SEG_MAP       : 7-segment patterns {dp,g,f,e,d,c,b,a} for 0..9,
//                       active-high, dp always 0
//     - bcd_clamp()   : forces a nibble above 9 down to 9
// ---------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } timer_state_t;

    localparam logic [7:0] SEG_MAP [10] = '{
        8'b00111111,  // 0
        8'b00000110,  // 1
        8'b01011011,  // 2
        8'b01001111,  // 3
        8'b01100110,  // 4
        8'b01101101,  // 5
        8'b01111101,  // 6
        8'b00000111,  // 7
        8'b01111111,  // 8
        8'b01101111   // 9
    };

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

endpackage

// File: rtl/bcd_scan_mux.sv
// ---------------------------------------------------------------------------
// bcd_scan_mux
//   Multiplexed 7-segment scan driver. Every SCAN_DIV clocks the selected
//   digit advances one position toward the MSB, wrapping to digit 0. The
//   segment pattern is decoded from the currently selected digit, so seg and
//   com always change on the same clock edge.
//
//   Parameters: DIGITS (1..8), SCAN_DIV (>=2) clocks per digit slot.
//   Ports:
//     clk    in   clock, posedge
//     rst    in   asynchronous active-low reset (selects digit 0)
//     value  in   4*DIGITS BCD digits, digit 0 in [3:0]
//     seg    out  {dp,g..a}, active-high, dp = 0
//     com    out  one-hot digit select, active-high
// ---------------------------------------------------------------------------
module bcd_scan_mux
    import timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 65536
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     com
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

    logic [SCAN_W-1:0] r_scan;
    logic [IDX_W-1:0]  r_idx;
    logic [3:0]        w_digit;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else if (r_scan == SCAN_MAX) begin
            r_scan <= '0;
            r_idx  <= (r_idx == IDX_MAX) ? '0 : r_idx + 1'b1;
        end else begin
            r_scan <= r_scan + 1'b1;
        end
    end

    // NOTE: combinational outputs get a default before any conditional
    // assignment so no path leaves them unassigned (no latch).
    always_comb begin
        w_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = value[4*i +: 4];
            end
        end
    end

    // The digit is always valid BCD; the clamp only keeps the table index
    // inside its ten entries.
    assign seg = SEG_MAP[bcd_clamp(w_digit)];
    assign com = DIGITS'(1) << r_idx;

endmodule

// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
//   Multi-digit BCD countdown timer with loadable preset, start/pause
//   control, multiplexed 7-segment display and end-of-count alarm tone.
//   All timing is derived from clk through clock-enable counters.
//
//   Build option: define TIMER_ALARM_EN to build the ALARM state and the
//   tone generator. Without it, reaching 0 returns straight to IDLE with a
//   one-cycle done pulse and spk is tied low.
//
//   Parameters: DIGITS (1..8), TICK_DIV, SCAN_DIV, TONE_DIV (>=2 each),
//               ALARM_TICKS (>=1).
//   Ports:
//     clk       in   clock, posedge
//     rst       in   asynchronous active-low reset
//     load      in   pulse: value <= clamped load_val, state -> IDLE/RUN
//     load_val  in   preset, 4*DIGITS BCD, digit 0 in [3:0]
//     start     in   pulse: start / resume / alarm acknowledge
//     pause     in   pulse: freeze the count while running
//     seg       out  segment pattern {dp,g..a}, active-high
//     com       out  one-hot digit select, active-high
//     spk       out  alarm square wave
//     running   out  high in RUN
//     done      out  high in ALARM (one-cycle pulse without the alarm)
//     value     out  current count, BCD
// ---------------------------------------------------------------------------
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TICK_DIV    = 25000000,
    parameter int SCAN_DIV    = 65536,
    parameter int TONE_DIV    = 15625,
    parameter int ALARM_TICKS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     com,
    output logic                  spk,
    output logic                  running,
    output logic                  done,
    output logic [4*DIGITS-1:0]   value
);

    if (DIGITS < 1 || DIGITS > 8 || TICK_DIV < 2 || SCAN_DIV < 2 ||
        TONE_DIV < 2 || ALARM_TICKS < 1) begin : g_bad_cfg
        $error("bcd_countdown_timer: parameter out of range");
    end

    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'd9}};

`ifdef TIMER_ALARM_EN
    localparam timer_state_t ST_AT_ZERO = ST_ALARM;
    localparam int ALARM_W = $clog2(ALARM_TICKS + 1);
    localparam int TONE_W  = $clog2(TONE_DIV);
    localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_TICKS - 1);
    localparam logic [TONE_W-1:0]  TONE_MAX   = TONE_W'(TONE_DIV - 1);

    logic [ALARM_W-1:0] r_alarm_cnt;
    logic [TONE_W-1:0]  r_tone_cnt;
    logic               r_spk;
    logic               w_alarm_last;
    logic               w_tone_tick;
`else
    localparam timer_state_t ST_AT_ZERO = ST_IDLE;

    logic               r_done_pulse;
`endif

    timer_state_t         r_state;
    timer_state_t         w_next_state;
    logic [4*DIGITS-1:0]  r_value;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   w_presc_inc;
    logic [4*DIGITS-1:0]  w_load_clamped;
    logic [4*DIGITS-1:0]  w_val_dec;
    logic                 w_val_zero;
    logic                 w_dec_zero;
    logic                 w_tick;
    logic                 w_pause_take;
    logic                 w_run_dec;

    // -----------------------------------------------------------------------
    // Datapath helpers
    // -----------------------------------------------------------------------
    always_comb begin
        w_load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
        end
    end

    // Ripple-borrow BCD decrement: zeros become 9 until the first non-zero
    // digit absorbs the borrow.
    always_comb begin : p_bcd_dec
        logic w_borrow;
        w_borrow  = 1'b1;
        w_val_dec = r_value;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_borrow) begin
                if (r_value[4*i +: 4] == 4'd0) begin
                    w_val_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_val_dec[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
                    w_borrow            = 1'b0;
                end
            end
        end
    end

    assign w_val_zero  = (r_value == '0);
    assign w_dec_zero  = (w_val_dec == '0);
    assign w_presc_inc = (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
    assign w_tick      = (r_presc == PRESC_MAX) &&
                         ((r_state == ST_RUN) || (r_state == ST_ALARM));

    // A pause accepted on a tick cycle wins over the decrement; the frozen
    // prescaler then fires the tick on the first cycle after resume.
    assign w_pause_take = (r_state == ST_RUN) && pause && !start && !load;
    assign w_run_dec    = (r_state == ST_RUN) && w_tick && !w_pause_take && !load;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        if (load) begin
            w_next_state = start ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && !w_val_zero) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_pause_take) begin
                        w_next_state = ST_PAUSE;
                    end else if (w_run_dec && w_dec_zero) begin
                        w_next_state = ST_AT_ZERO;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        w_next_state = ST_RUN;
                    end
                end
                ST_ALARM: begin
`ifdef TIMER_ALARM_EN
                    if (start || (w_tick && w_alarm_last)) begin
                        w_next_state = ST_IDLE;
                    end
`else
                    w_next_state = ST_IDLE;
`endif
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        running = (r_state == ST_RUN);
`ifdef TIMER_ALARM_EN
        done    = (r_state == ST_ALARM);
`else
        done    = r_done_pulse;
`endif
    end

    // -----------------------------------------------------------------------
    // Count value and tick prescaler
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= ALL_NINES;
            r_presc <= '0;
        end else begin
            if (load) begin
                r_value <= w_load_clamped;
            end else if (w_run_dec) begin
                r_value <= w_val_dec;
            end

            // Cleared while idle so a start from IDLE always gives a full
            // TICK_DIV interval; held while paused.
            if (load) begin
                r_presc <= '0;
            end else begin
                case (r_state)
                    ST_RUN:   if (!w_pause_take) r_presc <= w_presc_inc;
                    ST_PAUSE: r_presc <= r_presc;
                    ST_ALARM: r_presc <= start ? '0 : w_presc_inc;
                    default:  r_presc <= '0;
                endcase
            end
        end
    end

`ifdef TIMER_ALARM_EN
    // -----------------------------------------------------------------------
    // Alarm duration and tone generator
    // -----------------------------------------------------------------------
    assign w_alarm_last = (r_alarm_cnt == ALARM_LAST);
    assign w_tone_tick  = (r_tone_cnt == TONE_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alarm_cnt <= '0;
            r_tone_cnt  <= '0;
            r_spk       <= 1'b0;
        end else begin
            // Zero outside ALARM, so counting restarts on every entry.
            if (r_state != ST_ALARM) begin
                r_alarm_cnt <= '0;
            end else if (w_tick) begin
                r_alarm_cnt <= r_alarm_cnt + 1'b1;
            end

            // The tone divider free-runs; only the speaker is gated.
            r_tone_cnt <= w_tone_tick ? '0 : r_tone_cnt + 1'b1;

            if (w_next_state != ST_ALARM) begin
                r_spk <= 1'b0;
            end else if (w_tone_tick) begin
                r_spk <= ~r_spk;
            end
        end
    end

    assign spk = r_spk;
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_pulse <= 1'b0;
        end else begin
            r_done_pulse <= w_run_dec && w_dec_zero;
        end
    end

    assign spk = 1'b0;
`endif

    assign value = r_value;

    // -----------------------------------------------------------------------
    // Display scan
    // -----------------------------------------------------------------------
    bcd_scan_mux #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .value (r_value),
        .seg   (seg),
        .com   (com)
    );

endmodule
